lut_arbiter: RTL and testbench

Shares one fixed-function lookup table instance (`sin_2pi_lut_16` or `tanh_4_lut_16`) between N requesters. Requests are granted round-robin, and one LUT access is sequenced at a time. The block linearly interpolates the returned base/next sample pair using the LUT's fractional index. It sits between the effect datapaths (oscillators, waveshapers) and the single LUT block RAM they would otherwise each need to duplicate.

---
 rtl/lut_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_lut_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_arbiter.sv
// ---------------------------------------------------------------------------
// lut_arbiter
//
// Shares a single fixed-function lookup table between N_REQ requesters.
// Requests are granted round-robin, one LUT access is in flight at a time,
// and the returned base/next sample pair is linearly interpolated using the
// LUT's fractional index.
//
// Handshake: each requester raises req[i] with a stable argument on its
// x_flat slice and keeps both steady until it sees the one-cycle ack[i]
// pulse; result is valid in that same cycle and the requester drops req[i]
// on the edge that ends it. Toward the LUT, lut_read is a one-cycle strobe
// with lut_x held stable until the LUT returns a one-cycle lut_valid pulse
// carrying lut_base/lut_next/lut_frac.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   req          : per-requester request levels
//   x_flat       : requester arguments, 16 bits each, signed Q15
//   ack          : one-hot grant-complete pulse
//   result       : interpolated sample, held until the next ack
//   busy         : high from grant until the ack cycle inclusive
//   lut_read     : one-cycle read strobe to the LUT
//   lut_x        : LUT argument
//   lut_valid    : LUT completion pulse
//   lut_base     : LUT sample at the integer index (signed)
//   lut_next     : LUT sample at the following index (signed)
//   lut_frac     : LUT fractional index (unsigned)
//   dbg_state    : current FSM state, for observation only
// ---------------------------------------------------------------------------
`ifndef LUT_FRAC_WIDTH
`define LUT_FRAC_WIDTH 4
`endif

module lut_arbiter #(
   parameter int N_REQ      = 4,
   parameter int FRAC_WIDTH = `LUT_FRAC_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [16*N_REQ-1:0]     x_flat,
   output logic [N_REQ-1:0]        ack,
   output logic [15:0]             result,
   output logic                    busy,
   output logic                    lut_read,
   output logic [15:0]             lut_x,
   input  logic                    lut_valid,
   input  logic [15:0]             lut_base,
   input  logic [15:0]             lut_next,
   input  logic [FRAC_WIDTH-1:0]   lut_frac,
   output logic [2:0]              dbg_state
);

   localparam int IW = $clog2(N_REQ);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_INTERP = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]          grant_q, grant_d;
   logic [15:0]            lut_x_q, lut_x_d;
   logic [15:0]            base_q, base_d;
   logic [15:0]            next_q, next_d;
   logic [FRAC_WIDTH-1:0]  frac_q, frac_d;
   logic [15:0]            result_q, result_d;
   logic [N_REQ-1:0]       ack_q, ack_d;
   logic                   busy_q, busy_d;
   logic                   lut_read_q, lut_read_d;

   // Round-robin pick: first set req bit at or above rr_ptr, wrapping.
   logic                   pick_valid;
   logic [IW-1:0]          pick_idx;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      // Walk offsets from farthest to nearest so the nearest set bit wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr_q) + k) % N_REQ]) begin
            pick_valid = 1'b1;
            pick_idx   = IW'((int'(rr_ptr_q) + k) % N_REQ);
         end
      end
   end

   // Interpolation datapath. The result always lies between base and next,
   // so truncating the sum to 16 bits never wraps.
   logic signed [16:0]             diff;
   logic signed [17+FRAC_WIDTH:0]  prod;
   logic signed [17+FRAC_WIDTH:0]  prod_shr;

   always_comb begin
      diff     = $signed({next_q[15], next_q}) - $signed({base_q[15], base_q});
      prod     = diff * $signed({1'b0, frac_q});
      prod_shr = prod >>> FRAC_WIDTH;
   end

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         lut_x_q    <= '0;
         base_q     <= '0;
         next_q     <= '0;
         frac_q     <= '0;
         result_q   <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
         lut_read_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         lut_x_q    <= lut_x_d;
         base_q     <= base_d;
         next_q     <= next_d;
         frac_q     <= frac_d;
         result_q   <= result_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         lut_read_q <= lut_read_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (pick_valid) state_d = S_ISSUE;
         S_ISSUE:  state_d = S_WAIT;
         S_WAIT:   if (lut_valid) state_d = S_INTERP;
         S_INTERP: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values. Every output is set up one cycle ahead
   // so that it appears registered in the state it belongs to.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      lut_x_d    = lut_x_q;
      base_d     = base_q;
      next_d     = next_q;
      frac_d     = frac_q;
      result_d   = result_q;
      ack_d      = '0;
      busy_d     = busy_q;
      lut_read_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               grant_d    = pick_idx;
               lut_x_d    = x_flat[int'(pick_idx)*16 +: 16];
               lut_read_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         S_WAIT: begin
            if (lut_valid) begin
               base_d = lut_base;
               next_d = lut_next;
               frac_d = lut_frac;
            end
         end
         S_INTERP: begin
            result_d       = 16'($signed(base_q) + prod_shr);
            ack_d[grant_q] = 1'b1;
         end
         S_DONE: begin
            busy_d   = 1'b0;
            rr_ptr_d = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign ack       = ack_q;
   assign result    = result_q;
   assign busy      = busy_q;
   assign lut_read  = lut_read_q;
   assign lut_x     = lut_x_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_lut_arbiter.sv
module tb_lut_arbiter;
   localparam int N  = 4;
   localparam int FW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [N-1:0]     req;
   logic [16*N-1:0]  x_flat;
   logic [N-1:0]     ack;
   logic [15:0]      result;
   logic             busy;
   logic             lut_read;
   logic [15:0]      lut_x;
   logic             lut_valid;
   logic [15:0]      lut_base;
   logic [15:0]      lut_next;
   logic [FW-1:0]    lut_frac;
   logic [2:0]       dbg_state;

   lut_arbiter #(.N_REQ(N), .FRAC_WIDTH(FW)) dut (
      .clk(clk), .reset(reset), .req(req), .x_flat(x_flat),
      .ack(ack), .result(result), .busy(busy), .lut_read(lut_read),
      .lut_x(lut_x), .lut_valid(lut_valid), .lut_base(lut_base),
      .lut_next(lut_next), .lut_frac(lut_frac), .dbg_state(dbg_state)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference helpers ----------------
   int sin_tab[2048];
   initial begin
      for (int i = 0; i < 2048; i++)
         sin_tab[i] = int'($floor(32767.0 * $sin(2.0 * 3.14159265358979 * i / 2048.0) + 0.5));
   end

   // base + floor((next-base)*frac / 2^FW), using integer division
   function automatic logic [15:0] ref_interp(input logic [15:0] b, input logic [15:0] n,
                                              input logic [FW-1:0] f);
      int bi, ni, p, q;
      bi = int'($signed(b));
      ni = int'($signed(n));
      p  = (ni - bi) * int'(f);
      q  = p / (1 << FW);
      if (p < 0 && q * (1 << FW) != p) q = q - 1;
      return 16'(bi + q);
   endfunction

   // ---------------- LUT model ----------------
   int             lat = 5;
   bit             sine_mode = 0;
   bit             rand_data = 0;
   bit             spur = 0;
   logic [15:0]    fix_base = 16'h0, fix_next = 16'h0;
   logic [FW-1:0]  fix_frac = '0;

   initial begin : lut_model
      int cnt;
      logic rst_seen;
      logic [15:0] cap_x;
      int idx;
      cnt = 0; cap_x = '0;
      lut_valid = 0; lut_base = '0; lut_next = '0; lut_frac = '0;
      forever begin
         @(posedge clk);
         rst_seen = reset;
         #1;
         lut_valid = 0;
         if (rst_seen) cnt = 0;
         else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  lut_valid = 1;
                  if (sine_mode) begin
                     idx      = int'(cap_x[14:4]);
                     lut_base = 16'(sin_tab[idx]);
                     lut_next = 16'(sin_tab[(idx + 1) % 2048]);
                     lut_frac = cap_x[3:0];
                  end else if (rand_data) begin
                     lut_base = 16'($urandom);
                     lut_next = 16'($urandom);
                     lut_frac = FW'($urandom);
                  end else begin
                     lut_base = fix_base;
                     lut_next = fix_next;
                     lut_frac = fix_frac;
                  end
               end
            end
            if (lut_read) begin
               cnt   = lat;
               cap_x = lut_x;
            end
         end
         if (spur) begin
            spur      = 0;
            lut_valid = 1;
            lut_base  = 16'($urandom);
            lut_next  = 16'($urandom);
            lut_frac  = FW'($urandom);
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [N+15:0] exp_q[$];
   int            exp_cyc_q[$];

   // Behavioural model: round-robin grant, one transaction at a time.
   initial begin : ref_model
      bit   m_idle, m_wait, prev_rst, found;
      int   m_ptr, m_grant, rd_cyc, done_cyc, j;
      logic [15:0] m_x;
      logic [N-1:0] oh;
      m_idle = 1; m_wait = 0; prev_rst = 0;
      m_ptr = 0; m_grant = 0; rd_cyc = -1; done_cyc = -1; m_x = '0;
      forever begin
         @(negedge clk);
         if (prev_rst) begin
            check("rst_ack", 32'(ack), 32'h0);
            check("rst_lut_read", 32'(lut_read), 32'h0);
            check("rst_result", 32'(result), 32'h0);
            check("rst_lut_x", 32'(lut_x), 32'h0);
         end
         check("busy", 32'(busy), 32'(!m_idle));
         check("lut_read", 32'(lut_read), 32'(cyc == rd_cyc));
         if (cyc == rd_cyc) check("lut_x", 32'(lut_x), 32'(m_x));
         if (m_wait) check("lut_x_hold", 32'(lut_x), 32'(m_x));
         if (reset) begin
            m_idle = 1; m_wait = 0; m_ptr = 0; rd_cyc = -1; done_cyc = -1;
            exp_q.delete(); exp_cyc_q.delete();
            prev_rst = 1;
         end else begin
            prev_rst = 0;
            if (m_wait && lut_valid) begin
               oh = '0; oh[m_grant] = 1'b1;
               exp_q.push_back({oh, ref_interp(lut_base, lut_next, lut_frac)});
               exp_cyc_q.push_back(cyc + 2);
               done_cyc = cyc + 2;
               m_wait = 0;
            end
            if (cyc == rd_cyc) m_wait = 1;
            if (cyc == done_cyc) m_idle = 1;
            else if (m_idle && req != '0) begin
               found = 0;
               for (int k = 0; k < N; k++) begin
                  j = (m_ptr + k) % N;
                  if (!found && req[j]) begin
                     found = 1; m_grant = j;
                  end
               end
               m_x    = x_flat[16*m_grant +: 16];
               rd_cyc = cyc + 1;
               m_ptr  = (m_grant + 1) % N;
               m_idle = 0;
            end
         end
      end
   end

   // Monitor: compares every ack against the head of the expected queue.
   initial begin : monitor
      logic [N+15:0] e;
      int ec;
      forever begin
         @(negedge clk);
         if (ack !== '0) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_ack: got ack=%b result=%h expected none (cycle %0d)", ack, result, cyc);
            end else begin
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               check("ack", 32'(ack), 32'(e[N+15:16]));
               check("result", 32'(result), 32'(e[15:0]));
               check("ack_cycle", 32'(cyc), 32'(ec));
            end
         end
      end
   end

   // Requesters drop req in their ack cycle.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (ack[i] === 1'b1) req[i] = 1'b0;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_x(input int i, input logic [15:0] v);
      x_flat[16*i +: 16] = v;
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      while ((req != '0 || busy || exp_q.size() != 0) && n < 500) begin
         tick(); n++;
      end
      total++;
      if (n >= 500) begin
         bad++;
         $display("FAIL quiet_timeout: got still busy after %0d cycles expected idle", n);
      end
      tick(); tick();
   endtask

   task automatic wait_read();
      int n;
      n = 0;
      while (lut_read !== 1'b1 && n < 50) begin
         tick(); n++;
      end
      total++;
      if (n >= 50) begin
         bad++;
         $display("FAIL read_timeout: got no lut_read expected one within 50 cycles");
      end
   endtask

   task automatic fixed_req(input int i, input logic [15:0] x, input logic [15:0] b,
                            input logic [15:0] nx, input logic [FW-1:0] f);
      fix_base = b; fix_next = nx; fix_frac = f;
      set_x(i, x);
      req[i] = 1'b1;
      wait_quiet();
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [N-1:0] m;
      reset = 1; req = '0; x_flat = '0;
      repeat (3) tick();
      reset = 0;
      tick();

      // directed interpolation cases, 5-cycle LUT
      lat = 5;
      fixed_req(1, 16'h1234, 16'h1000, 16'h2000, 4'd8);
      fixed_req(0, 16'h0100, 16'h2000, 16'h1000, 4'd4);
      fixed_req(2, 16'h0200, 16'h0000, 16'hFFFF, 4'd1);
      fixed_req(3, 16'h0300, 16'h1234, 16'h7000, 4'd0);
      fixed_req(1, 16'h0400, 16'h8000, 16'h7FFF, 4'd15);

      // round-robin
      rand_data = 1;
      for (int i = 0; i < N; i++) set_x(i, 16'($urandom));
      req = 4'b1111;
      wait_quiet();
      req = 4'b1001;
      wait_quiet();
      req = 4'b0001;
      wait_quiet();
      req = 4'b1001;
      wait_quiet();

      // spurious lut_valid while idle
      spur = 1;
      repeat (4) tick();

      // reset one cycle after lut_read
      set_x(2, 16'h2222);
      req[2] = 1'b1;
      wait_read();
      tick();
      reset = 1; req = '0;
      tick();
      reset = 0;
      repeat (3) tick();
      req = 4'b1010;
      wait_quiet();

      // req dropped and x changed during WAIT
      set_x(2, 16'h4444);
      req[2] = 1'b1;
      wait_read();
      tick();
      req[2] = 1'b0;
      set_x(2, 16'h5555);
      wait_quiet();

      // sine table
      rand_data = 0; sine_mode = 1;
      set_x(0, 16'h0000); req[0] = 1'b1; wait_quiet();
      set_x(1, 16'h2000); req[1] = 1'b1; wait_quiet();
      for (int r = 0; r < 6; r++) begin
         set_x(r % N, 16'($urandom));
         req[r % N] = 1'b1;
         wait_quiet();
      end

      // random traffic
      sine_mode = 0; rand_data = 1;
      for (int r = 0; r < 40; r++) begin
         lat = $urandom_range(1, 8);
         m = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++)
            if (m[i] && !req[i]) set_x(i, 16'($urandom));
         req = req | m;
         repeat ($urandom_range(1, 15)) tick();
      end
      wait_quiet();

      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
